// File: rtl/palette_index_unpacker_pkg.sv
// palette_index_unpacker_pkg: shared display-path constants and types
package palette_index_unpacker_pkg;
    localparam int DISPLAY_WORD_WIDTH = 32;
    localparam int DISPLAY_ID_WIDTH = 3;
    localparam int DISPLAY_PIXELS_PER_WORD = DISPLAY_WORD_WIDTH / DISPLAY_ID_WIDTH;
    typedef enum logic {EMPTY, ACTIVE} unpack_state_t;
    typedef logic [DISPLAY_ID_WIDTH-1:0] palette_id_t;
endpackage

// File: rtl/palette_index_unpacker_shaper_word_fifo.sv
// shaper_word_fifo: synchronous word FIFO with occupancy count and flush
module shaper_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign rdata = mem[rd_ptr];
    // storage needs no reset; pointers and count alone define which entries are live
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wdata;
    // pointer and occupancy bookkeeping; flush simply rewinds everything
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
endmodule

// File: rtl/palette_index_unpacker.sv
// palette_index_unpacker: buffers packed framebuffer words and emits one palette ID per pixel strobe
module palette_index_unpacker
    import palette_index_unpacker_pkg::*;
#(
    parameter int WORD_WIDTH = DISPLAY_WORD_WIDTH,
    parameter int ID_WIDTH = DISPLAY_ID_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  aClock,
    input  logic                  aReset,
    input  logic [WORD_WIDTH-1:0] aWordData,
    input  logic                  aWordValid,
    output logic                  anOutWordReady,
    input  logic                  aPixelRequest,
    input  logic                  aFrameStart,
    output logic [ID_WIDTH-1:0]   anOutPaletteID,
    output logic                  anOutPaletteValid,
    output logic                  anOutUnderflow
);
    localparam int PIXELS_PER_WORD = WORD_WIDTH / ID_WIDTH;
    localparam int PW = $clog2(PIXELS_PER_WORD);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PW-1:0] LAST_PIXEL = PW'(PIXELS_PER_WORD - 1);
    logic [CW-1:0] count;
    logic [WORD_WIDTH-1:0] head, word;
    logic [PW-1:0] pixel;
    unpack_state_t state;
    logic push, pop, has_word, last, serve;
    assign anOutWordReady = !aReset && !aFrameStart && count < CW'(FIFO_DEPTH);
    assign push = aWordValid && anOutWordReady;
    assign has_word = count != '0;
    assign last = pixel == LAST_PIXEL;
    assign serve = aPixelRequest && state == ACTIVE;
    // refill when idle, or chain straight into the next word on the final pixel
    assign pop = !aFrameStart && has_word && (state == EMPTY || (serve && last));
    shaper_word_fifo #(.WIDTH(WORD_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(aClock),
        .rst(aReset),
        .flush(aFrameStart),
        .push(push),
        .pop(pop),
        .wdata(aWordData),
        .rdata(head),
        .count(count)
    );
    // current-word state machine with registered pixel, valid and sticky underflow outputs
    always_ff @(posedge aClock or posedge aReset)
        if (aReset) begin
            state <= EMPTY;
            word <= '0;
            pixel <= '0;
            anOutPaletteID <= '0;
            anOutPaletteValid <= 1'b0;
            anOutUnderflow <= 1'b0;
        end else if (aFrameStart) begin
            state <= EMPTY;
            word <= '0;
            pixel <= '0;
            anOutPaletteValid <= 1'b0;
            anOutUnderflow <= 1'b0;
        end else begin
            anOutPaletteValid <= serve;
            if (aPixelRequest && state == EMPTY) begin
                anOutPaletteID <= '0;
                anOutUnderflow <= 1'b1;
            end
            if (serve) anOutPaletteID <= ID_WIDTH'(word >> (pixel * ID_WIDTH));
            if (pop) begin
                word <= head;
                pixel <= '0;
                state <= ACTIVE;
            end else if (serve) begin
                pixel <= last ? '0 : pixel + 1'b1;
                if (last) begin
                    state <= EMPTY;
                    word <= '0;
                end
            end
        end
endmodule

// File: tb/tb_palette_index_unpacker.sv
// tb_palette_index_unpacker: scenario and random checks against a queue-based pixel stream model
module tb_palette_index_unpacker;
    logic aClock = 1'b0, aReset = 1'b1;
    logic [31:0] aWordData = '0;
    logic aWordValid = 1'b0, aPixelRequest = 1'b0, aFrameStart = 1'b0;
    logic anOutWordReady, anOutPaletteValid, anOutUnderflow;
    logic [2:0] anOutPaletteID;
    int errors = 0, checks = 0, accepted = 0;
    logic [31:0] wq[$];
    int pix[$];
    logic [2:0] m_id;
    logic m_valid, m_uf, m_ready, obs_ready;

    palette_index_unpacker dut (
        .aClock(aClock),
        .aReset(aReset),
        .aWordData(aWordData),
        .aWordValid(aWordValid),
        .anOutWordReady(anOutWordReady),
        .aPixelRequest(aPixelRequest),
        .aFrameStart(aFrameStart),
        .anOutPaletteID(anOutPaletteID),
        .anOutPaletteValid(anOutPaletteValid),
        .anOutUnderflow(anOutUnderflow)
    );

    always #5 aClock = ~aClock;

    task automatic model_reset();
        wq.delete();
        pix.delete();
        m_id = '0;
        m_valid = 1'b0;
        m_uf = 1'b0;
    endtask

    // Model: a word queue feeding a queue of pending pixels; a request consumes one pixel,
    // and whenever no pixels remain at the end of a cycle the oldest stored word is unpacked.
    task automatic cycle(input logic req, input logic v, input logic [31:0] d, input logic fs);
        logic [31:0] w;
        aPixelRequest = req;
        aWordValid = v;
        aWordData = d;
        aFrameStart = fs;
        #1 obs_ready = anOutWordReady;
        m_ready = !fs && wq.size() < 4;
        if (fs) begin
            wq.delete();
            pix.delete();
            m_valid = 1'b0;
            m_uf = 1'b0;
        end else begin
            m_valid = req && pix.size() > 0;
            if (req && m_valid) m_id = 3'(pix.pop_front());
            else if (req) begin
                m_id = '0;
                m_uf = 1'b1;
            end
            if (pix.size() == 0 && wq.size() > 0) begin
                w = wq.pop_front();
                for (int k = 0; k < 10; k++) pix.push_back(int'((w >> (3 * k)) & 32'd7));
            end
            if (v && m_ready) wq.push_back(d);
        end
        if (v && obs_ready) accepted++;
        @(posedge aClock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if ({anOutPaletteID, anOutPaletteValid, anOutUnderflow, anOutWordReady} !== 6'b0) begin errors++; $display("FAIL reset_outputs got id=%0d v=%b uf=%b rdy=%b want all 0", anOutPaletteID, anOutPaletteValid, anOutUnderflow, anOutWordReady); end
        @(posedge aClock); @(posedge aClock); #1;
        aReset = 1'b0;
        model_reset();
        cycle(0, 0, 0, 0);
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", obs_ready); end
    endtask

    task automatic test_basic();
        int exp_ids[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        cycle(0, 1, 32'h08FAC688, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 0, 0);
            checks++; if (anOutPaletteID !== 3'(exp_ids[i]) || anOutPaletteValid !== 1'b1 || anOutUnderflow !== 1'b0) begin errors++; $display("FAIL basic_pixel%0d got id=%0d v=%b uf=%b want id=%0d v=1 uf=0", i, anOutPaletteID, anOutPaletteValid, anOutUnderflow, exp_ids[i]); end
        end
        cycle(0, 0, 0, 0);
        checks++; if (anOutPaletteValid !== 1'b0 || anOutPaletteID !== m_id) begin errors++; $display("FAIL basic_idle got id=%0d v=%b want id=%0d v=0", anOutPaletteID, anOutPaletteValid, m_id); end
    endtask

    task automatic test_back_to_back();
        cycle(0, 1, 32'h08FAC688, 0);
        cycle(0, 1, 32'h3FFFFFFF, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 0, 0);
            checks++; if (anOutPaletteID !== m_id || anOutPaletteValid !== 1'b1 || anOutPaletteValid !== m_valid) begin errors++; $display("FAIL b2b_pixel%0d got id=%0d v=%b want id=%0d v=1", i, anOutPaletteID, anOutPaletteValid, m_id); end
        end
        checks++; if (anOutPaletteID !== 3'd7) begin errors++; $display("FAIL b2b_last got id=%0d want 7", anOutPaletteID); end
    endtask

    task automatic test_full();
        cycle(0, 1, $urandom, 0);
        cycle(0, 0, 0, 0);
        accepted = 0;
        for (int i = 0; i < 7; i++) begin
            cycle(0, 1, $urandom, 0);
            checks++; if (obs_ready !== m_ready) begin errors++; $display("FAIL full_ready%0d got %b want %b", i, obs_ready, m_ready); end
        end
        checks++; if (accepted !== 4) begin errors++; $display("FAIL full_accepted got %0d want 4", accepted); end
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
        cycle(0, 1, $urandom, 0);
        checks++; if (obs_ready !== 1'b1 || accepted !== 5) begin errors++; $display("FAIL full_refill got rdy=%b accepted=%0d want rdy=1 accepted=5", obs_ready, accepted); end
        for (int i = 0; i < 45; i++) begin
            cycle(1, 0, 0, 0);
            checks++; if (anOutPaletteID !== m_id || anOutPaletteValid !== m_valid) begin errors++; $display("FAIL full_drain%0d got id=%0d v=%b want id=%0d v=%b", i, anOutPaletteID, anOutPaletteValid, m_id, m_valid); end
        end
    endtask

    task automatic test_underflow();
        aReset = 1'b1;
        #2 aReset = 1'b0;
        model_reset();
        cycle(1, 0, 0, 0);
        checks++; if (anOutPaletteValid !== 1'b0 || anOutPaletteID !== 3'd0 || anOutUnderflow !== 1'b1) begin errors++; $display("FAIL underflow_set got id=%0d v=%b uf=%b want id=0 v=0 uf=1", anOutPaletteID, anOutPaletteValid, anOutUnderflow); end
        cycle(0, 0, 0, 0);
        cycle(0, 1, 32'h08FAC688, 0);
        checks++; if (anOutUnderflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky got %b want 1", anOutUnderflow); end
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        checks++; if (anOutPaletteValid !== 1'b1 || anOutPaletteID !== 3'd0 || anOutUnderflow !== 1'b1) begin errors++; $display("FAIL underflow_recover got id=%0d v=%b uf=%b want id=0 v=1 uf=1", anOutPaletteID, anOutPaletteValid, anOutUnderflow); end
    endtask

    task automatic test_flush();
        aReset = 1'b1;
        #2 aReset = 1'b0;
        model_reset();
        cycle(1, 0, 0, 0);
        cycle(0, 1, 32'h08FAC688, 0);
        cycle(0, 1, 32'h3FFFFFFF, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        checks++; if (anOutPaletteID !== 3'd2 || anOutUnderflow !== 1'b1) begin errors++; $display("FAIL flush_pre got id=%0d uf=%b want id=2 uf=1", anOutPaletteID, anOutUnderflow); end
        accepted = 0;
        cycle(1, 1, 32'h12345678, 1);
        checks++; if (obs_ready !== 1'b0 || accepted !== 0) begin errors++; $display("FAIL flush_push got rdy=%b accepted=%0d want rdy=0 accepted=0", obs_ready, accepted); end
        checks++; if (anOutPaletteValid !== 1'b0 || anOutUnderflow !== 1'b0) begin errors++; $display("FAIL flush_out got v=%b uf=%b want v=0 uf=0", anOutPaletteValid, anOutUnderflow); end
        cycle(1, 0, 0, 0);
        checks++; if (anOutPaletteValid !== 1'b0 || anOutPaletteID !== 3'd0 || anOutUnderflow !== 1'b1) begin errors++; $display("FAIL flush_empty got id=%0d v=%b uf=%b want id=0 v=0 uf=1", anOutPaletteID, anOutPaletteValid, anOutUnderflow); end
    endtask

    task automatic test_async_reset();
        cycle(0, 1, 32'h3FFFFFFF, 0);
        cycle(0, 1, 32'h3FFFFFFF, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        #2 aReset = 1'b1;
        #1;
        checks++; if ({anOutPaletteID, anOutPaletteValid, anOutUnderflow, anOutWordReady} !== 6'b0) begin errors++; $display("FAIL async_reset got id=%0d v=%b uf=%b rdy=%b want all 0", anOutPaletteID, anOutPaletteValid, anOutUnderflow, anOutWordReady); end
        @(posedge aClock); #1;
        aReset = 1'b0;
        model_reset();
        cycle(0, 1, 32'h08FAC688, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 0, 0);
            checks++; if (anOutPaletteID !== m_id || anOutPaletteValid !== 1'b1) begin errors++; $display("FAIL async_replay%0d got id=%0d v=%b want id=%0d v=1", i, anOutPaletteID, anOutPaletteValid, m_id); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom, $urandom_range(0, 49) == 0);
            checks++; if (obs_ready !== m_ready || anOutPaletteID !== m_id || anOutPaletteValid !== m_valid || anOutUnderflow !== m_uf) begin errors++; $display("FAIL random%0d got rdy=%b id=%0d v=%b uf=%b want rdy=%b id=%0d v=%b uf=%b", i, obs_ready, anOutPaletteID, anOutPaletteValid, anOutUnderflow, m_ready, m_id, m_valid, m_uf); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_full();
        test_underflow();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
